bcd_serial_subtractor: RTL and testbench

- Digit-serial N-digit BCD subtractor: computes A - B - Bin, one BCD digit per clock, least significant digit first.
- It is the complementary operation to the team's parallel N-digit BCD adder, and feeds the same decimal datapath.
- Start/busy/done handshake; operands captured on start; result registered and held until the next accepted start.

---
 rtl/bcd_serial_subtractor.sv | 146 ++++++++++++++
 tb/tb_bcd_serial_subtractor.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial N-digit BCD subtractor computing A - B - Bin, least significant digit first.
// Optional SIGN_MAG_EN macro adds a FIX pass that turns a negative result into sign/magnitude.
module bcd_serial_subtractor #(
    parameter int N = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [4*N-1:0]   A_in,
    input  logic [4*N-1:0]   B_in,
    input  logic             Bin_in,
    output logic             busy,
    output logic             done,
    output logic [4*N-1:0]   Diff_out,
    output logic             Bout_out,
    output logic             Neg_out,
    output logic             Err_out
);

    localparam int W  = 4 * N;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

`ifdef SIGN_MAG_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SUB = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;
    logic neg;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SUB = 2'd1, DONE = 2'd3} state_t;
`endif

    state_t        state;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic [W-1:0]  acc;
    logic          br;
    logic [CW-1:0] cnt;

    logic [3:0]    op_a;
    logic [3:0]    op_b;
    logic [5:0]    d;
    logic [5:0]    d_fix;
    logic [3:0]    dig;
    logic          dig_br;
    logic [W-1:0]  acc_next;

    // One shared digit slice; in FIX it subtracts the raw result from zero.
    always_comb begin
        op_a = a_reg[3:0];
        op_b = b_reg[3:0];
`ifdef SIGN_MAG_EN
        if (state == FIX) begin
            op_a = 4'd0;
            op_b = acc[3:0];
        end
`endif
        d      = {2'b00, op_a} - {2'b00, op_b} - {5'd0, br};
        d_fix  = d + 6'd10;
        dig    = d[3:0];
        dig_br = 1'b0;
        if (d[5]) begin
            dig    = d_fix[3:0];
            dig_br = 1'b1;
        end
        acc_next = (acc >> 4) | (W'(dig) << (W - 4));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            a_reg    <= '0;
            b_reg    <= '0;
            acc      <= '0;
            br       <= 1'b0;
            cnt      <= '0;
`ifdef SIGN_MAG_EN
            neg      <= 1'b0;
`endif
            busy     <= 1'b0;
            done     <= 1'b0;
            Diff_out <= '0;
            Bout_out <= 1'b0;
            Neg_out  <= 1'b0;
            Err_out  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg   <= A_in;
                        b_reg   <= B_in;
                        br      <= Bin_in;
                        acc     <= '0;
                        cnt     <= '0;
                        Err_out <= 1'b0;
                        busy    <= 1'b1;
                        state   <= SUB;
                    end
                end
                SUB: begin
                    acc   <= acc_next;
                    a_reg <= a_reg >> 4;
                    b_reg <= b_reg >> 4;
                    br    <= dig_br;
                    cnt   <= cnt + 1'b1;
                    if (op_a > 4'd9 || op_b > 4'd9) Err_out <= 1'b1;
                    if (cnt == LAST) begin
`ifdef SIGN_MAG_EN
                        cnt <= '0;
                        neg <= dig_br;
                        if (dig_br) begin
                            br    <= 1'b0;
                            state <= FIX;
                        end else begin
                            state <= DONE;
                        end
`else
                        state <= DONE;
`endif
                    end
                end
`ifdef SIGN_MAG_EN
                FIX: begin
                    acc <= acc_next;
                    br  <= dig_br;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) state <= DONE;
                end
`endif
                DONE: begin
                    Diff_out <= acc;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    state    <= IDLE;
`ifdef SIGN_MAG_EN
                    Bout_out <= neg;
                    Neg_out  <= neg;
`else
                    Bout_out <= br;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Self-checking bench for bcd_serial_subtractor: directed cases plus random BCD operands
// compared against an integer-arithmetic reference model.
module tb_bcd_serial_subtractor;

    localparam int N  = 2;
    localparam int W  = 4 * N;
    localparam int RW = W + 3;

    logic          clk;
    logic          rst;
    logic          start;
    logic [W-1:0]  a_in;
    logic [W-1:0]  b_in;
    logic          bin_in;
    logic          busy;
    logic          done;
    logic [W-1:0]  diff_out;
    logic          bout_out;
    logic          neg_out;
    logic          err_out;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    logic [RW-1:0] exp_q[$];
    int            lat_q[$];

    bcd_serial_subtractor #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .A_in     (a_in),
        .B_in     (b_in),
        .Bin_in   (bin_in),
        .busy     (busy),
        .done     (done),
        .Diff_out (diff_out),
        .Bout_out (bout_out),
        .Neg_out  (neg_out),
        .Err_out  (err_out)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // reference model: whole-number decimal arithmetic
    function automatic int bcd_to_int(input logic [W-1:0] v);
        int r;
        r = 0;
        for (int k = N - 1; k >= 0; k--) r = r * 10 + int'(v[4*k +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int_to_bcd(input int v);
        logic [W-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int k = 0; k < N; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                                  output logic [RW-1:0] exp, output int lat);
        int d;
        logic err, bout, neg;
        logic [W-1:0] res;
        err = 1'b0;
        neg = 1'b0;
        for (int k = 0; k < N; k++)
            if (a[4*k +: 4] > 4'd9 || b[4*k +: 4] > 4'd9) err = 1'b1;
        d    = bcd_to_int(a) - bcd_to_int(b) - int'(bin);
        bout = (d < 0);
        lat  = N + 1;
        if (d < 0) begin
`ifdef SIGN_MAG_EN
            res = int_to_bcd(-d);
            neg = 1'b1;
            lat = 2 * N + 1;
`else
            res = int_to_bcd(d + 10 ** N);
`endif
        end else begin
            res = int_to_bcd(d);
        end
        exp = {res, bout, neg, err};
    endfunction

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] r;
        for (int k = 0; k < N; k++) r[4*k +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    // driver: one full operation, checked through the scoreboard
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        logic [RW-1:0] e;
        int lat;
        int cyc;
        model(a, b, bin, e, lat);
        exp_q.push_back(e);
        lat_q.push_back(lat);
        @(negedge clk);
        a_in = a; b_in = b; bin_in = bin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 50) begin
            if (cyc >= 1) check("busy_during_op", 32'(busy), 32'd1);
            @(negedge clk);
            cyc++;
        end
        check("done_seen", 32'(done), 32'd1);
        e   = exp_q.pop_front();
        lat = lat_q.pop_front();
        if (done === 1'b1) begin
            check("latency", 32'(cyc), 32'(lat));
            check("result", 32'({diff_out, bout_out, neg_out, err_out}), 32'(e));
            check("busy_at_done", 32'(busy), 32'd0);
            @(negedge clk);
            check("done_single", 32'(done), 32'd0);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check(tag, 32'({busy, done, diff_out, bout_out, neg_out, err_out}), 32'd0);
    endtask

    // stimulus
    initial begin
        logic [RW-1:0] e;
        int lat;
        int base;
        int cyc;

        rst = 1'b0; start = 1'b0; a_in = '0; b_in = '0; bin_in = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // activity, then 2-cycle reset mid-operation
        @(negedge clk);
        a_in = 8'h77; b_in = 8'h12; bin_in = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        base = done_cnt;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        check_zero_outputs("reset_outputs");
        repeat (6) @(negedge clk);
        check("no_done_after_reset", 32'(done_cnt - base), 32'd0);
        check_zero_outputs("outputs_stay_zero");

        // directed cases
        do_op(8'h58, 8'h23, 1'b0);
        repeat (2) @(negedge clk);
        check("diff_hold", 32'(diff_out), 32'h35);
        do_op(8'h23, 8'h58, 1'b0);
        do_op(8'h00, 8'h00, 1'b1);
        do_op(8'h99, 8'h99, 1'b0);
        do_op(8'h00, 8'h99, 1'b0);
        do_op(8'h99, 8'h00, 1'b1);

        // invalid digit, then a valid op clears the error flag
        do_op(8'h1A, 8'h01, 1'b0);
        check("err_case_flag", 32'(err_out), 32'd1);
        do_op(8'h45, 8'h12, 1'b0);
        check("err_cleared", 32'(err_out), 32'd0);

        // start held with new operands while busy is ignored
        model(8'h58, 8'h23, 1'b0, e, lat);
        base = done_cnt;
        @(negedge clk);
        a_in = 8'h58; b_in = 8'h23; bin_in = 1'b0; start = 1'b1;
        @(negedge clk);
        a_in = 8'h99; b_in = 8'h11; bin_in = 1'b1;
        cyc = 0;
        while (done !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("busy_ign_done_seen", 32'(done), 32'd1);
        check("busy_ign_result", 32'({diff_out, bout_out, neg_out, err_out}), 32'(e));
        repeat (8) @(negedge clk);
        check("busy_ign_one_done", 32'(done_cnt - base), 32'd1);

        // reset one cycle after start, then normal operation
        base = done_cnt;
        @(negedge clk);
        a_in = 8'h58; b_in = 8'h23; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - base), 32'd0);
        check_zero_outputs("abort_outputs");
        do_op(8'h58, 8'h23, 1'b0);

        // random operands
        for (int i = 0; i < 40; i++)
            do_op(rand_bcd(), rand_bcd(), 1'($urandom_range(0, 1)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
